// File: rtl/carryskip_pipe_adder.sv
// Pipelined carry-skip adder/subtractor. Each stage resolves BPS skip blocks of
// BLK bits; pending operand bits ride input-skew registers, finished sum bits ride deskew registers.
module carryskip_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SW     = BLK * BPS;
  localparam int NSTAGE = WIDTH / SW;

  // The whole pipeline freezes while a result waits at the output.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // One stage slice: BPS ripple blocks, each followed by its skip mux.
  // Returns {carry_out, sum}.
  function automatic logic [SW:0] skip_slice(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          cin);
    logic [SW-1:0] sum;
    logic          c;
    logic          rc;
    logic          bp;
    logic          pi;
    // NOTE: blocking assignments are correct here: this is an ordered combinational
    // carry chain; clocked state elsewhere uses non-blocking so every flop sees pre-edge values.
    sum = '0;
    c   = cin;
    for (int j = 0; j < BPS; j++) begin
      rc = c;
      bp = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        pi               = x[j*BLK+i] ^ y[j*BLK+i];
        sum[j*BLK+i]     = pi ^ rc;
        rc               = (x[j*BLK+i] & y[j*BLK+i]) | (pi & rc);
        bp               = bp & pi;
      end
      c = bp ? c : rc;
    end
    return {c, sum};
  endfunction

  // Input capture: mode applied once, so later stages only see effective operands.
  logic             v0_q;
  logic             c0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] b0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      c0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
    end else if (advance) begin
      v0_q <= in_valid;
      c0_q <= sub ? 1'b1 : ci;
      a0_q <= a;
      b0_q <= sub ? ~b : b;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    localparam int LO   = k * SW;
    localparam int RIN  = WIDTH - LO;
    localparam int DONE = LO + SW;

    logic            v_cur;
    logic            c_cur;
    logic [RIN-1:0]  a_cur;
    logic [RIN-1:0]  b_cur;
    logic [DONE-1:0] res_nxt;
    logic [SW:0]     slice;
    logic            v_q;
    logic            c_q;
    logic [DONE-1:0] res_q;

    assign slice = skip_slice(a_cur[SW-1:0], b_cur[SW-1:0], c_cur);

    if (k == 0) begin : g_src
      assign v_cur   = v0_q;
      assign c_cur   = c0_q;
      assign a_cur   = a0_q;
      assign b_cur   = b0_q;
      assign res_nxt = slice[SW-1:0];
    end else begin : g_src
      assign v_cur   = g_stg[k-1].v_q;
      assign c_cur   = g_stg[k-1].c_q;
      assign a_cur   = g_stg[k-1].g_tail.a_rem_q;
      assign b_cur   = g_stg[k-1].g_tail.b_rem_q;
      assign res_nxt = {slice[SW-1:0], g_stg[k-1].res_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= v_cur;
        c_q   <= slice[SW];
        res_q <= res_nxt;
      end
    end

    if (k < NSTAGE - 1) begin : g_tail
      logic [RIN-SW-1:0] a_rem_q;
      logic [RIN-SW-1:0] b_rem_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (advance) begin
          a_rem_q <= a_cur[RIN-1:SW];
          b_rem_q <= b_cur[RIN-1:SW];
        end
      end
    end else begin : g_last
      logic ov_q;

      // Carry into the MSB is recovered as a^b^s at that bit, then compared with carry out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (advance) begin
          ov_q <= a_cur[SW-1] ^ b_cur[SW-1] ^ slice[SW-1] ^ slice[SW];
        end
      end
    end
  end

  assign out_valid = g_stg[NSTAGE-1].v_q;
  assign s         = g_stg[NSTAGE-1].res_q;
  assign co        = g_stg[NSTAGE-1].c_q;
  assign ovf       = g_stg[NSTAGE-1].g_last.ov_q;

endmodule
